// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts one BIN_W-bit unsigned operand per request into DIGITS packed BCD digits,
// processing one input bit per clock. The result is truncated to value mod 10^DIGITS.
//
// Optional feature: define BIN_TO_BCD_OVF_EN to add the ovf output, which flags
// inputs that do not fit in DIGITS digits.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   bin_in carries a value to convert
//   in_ready   out  converter idle and able to accept a value
//   bin_in     in   BIN_W-bit unsigned operand
//   out_valid  out  bcd_out holds a finished result
//   out_ready  in   downstream takes the result
//   bcd_out    out  packed BCD, digit k in [4k+3:4k]
//   busy       out  conversion in progress or result pending
//   ovf        out  (BIN_TO_BCD_OVF_EN only) input exceeded 10^DIGITS-1

module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
`ifdef BIN_TO_BCD_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    logic [BCD_W-1:0]       corr_c;
    logic [BCD_W+BIN_W-1:0] shifted_c;
    logic [BCD_W-1:0]       work_shift_c;
    logic [BIN_W-1:0]       bin_shift_c;

`ifdef BIN_TO_BCD_OVF_EN
    logic               ovf_acc_q, ovf_acc_d;
    logic               ovf_q, ovf_d;
    logic               carry_c;
`endif

    // One double-dabble iteration: +3 on every digit >= 5, then shift {bcd, bin} left.
    always_comb begin
        corr_c = work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                corr_c[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        // The top corrected bit falls off here; that is the truncation to DIGITS digits.
        shifted_c = {corr_c[BCD_W-2:0], bin_q, 1'b0};
        {work_shift_c, bin_shift_c} = shifted_c;
`ifdef BIN_TO_BCD_OVF_EN
        carry_c = corr_c[BCD_W-1];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)             state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_LAST)    state_d = S_DONE;
            S_DONE:  if (out_ready)            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d  = 1'b1;
            S_SHIFT: busy_d      = 1'b1;
            S_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Datapath next-state: latch on accept, iterate in SHIFT, publish result on entry to DONE.
    always_comb begin
        bin_d  = bin_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
`ifdef BIN_TO_BCD_OVF_EN
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d  = bin_in;
                    work_d = '0;
                    cnt_d  = '0;
`ifdef BIN_TO_BCD_OVF_EN
                    ovf_acc_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                bin_d  = bin_shift_c;
                work_d = work_shift_c;
                cnt_d  = CNT_W'(cnt_q + 1'b1);
`ifdef BIN_TO_BCD_OVF_EN
                ovf_acc_d = ovf_acc_q | carry_c;
`endif
                if (cnt_q == CNT_LAST) begin
                    bcd_d = work_shift_c;
`ifdef BIN_TO_BCD_OVF_EN
                    ovf_d = ovf_acc_q | carry_c;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
`ifdef BIN_TO_BCD_OVF_EN
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            bin_q  <= bin_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
`ifdef BIN_TO_BCD_OVF_EN
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd_out   = bcd_q;
`ifdef BIN_TO_BCD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: table-driven vectors with a scoreboard on
// the main instance (BIN_W=8, DIGITS=3), hand sequences for hold, reset and latency
// corners, and a DIGITS=2 instance for truncation (and ovf when enabled).

module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  bin_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] bcd_out;
    logic        busy;

    logic        iv2 = 1'b0;
    logic        ir2;
    logic [7:0]  bin2 = '0;
    logic        ov2;
    logic        or2 = 1'b0;
    logic [7:0]  bcd2;
    logic        busy2;
`ifdef BIN_TO_BCD_OVF_EN
    logic        ovf1;
    logic        ovf2;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [11:0] sb[$];

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;
    vec_t tbl[10];
    int   acc_cyc[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .busy(busy)
`ifdef BIN_TO_BCD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bin_in(bin2),
        .out_valid(ov2), .out_ready(or2), .bcd_out(bcd2), .busy(busy2)
`ifdef BIN_TO_BCD_OVF_EN
        , .ovf(ovf2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every output handshake pops one expected value.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got bcd_out=%h, want no output", bcd_out);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                if (bcd_out !== e) begin
                    n_err++;
                    $display("FAIL sb_bcd: got %h, want %h", bcd_out, e);
                end
            end
        end
    end

    // Drive one value on the main instance; push expectation when it will be accepted.
    task automatic send(input logic [7:0] v, input logic [11:0] e, input bit push, output int acc);
        bin_in   = v;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        else if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Run one conversion on the DIGITS=2 instance and leave it in DONE for inspection.
    task automatic run2(input logic [7:0] v, input logic [7:0] e);
        bin2 = v;
        iv2  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ir2) break;
        end
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (ov2) break;
            @(posedge clk);
            #1;
        end
        chk("d2_valid", 32'(ov2), 32'd1);
        chk("d2_bcd", 32'(bcd2), 32'(e));
    endtask

    task automatic release2();
        or2 = 1'b1;
        @(posedge clk);
        #1;
        or2 = 1'b0;
    endtask

    initial begin
        int acc;
        int lat;
        bit bad;

        tbl[0] = '{8'd0,   12'h000};
        tbl[1] = '{8'd99,  12'h099};
        tbl[2] = '{8'd100, 12'h100};
        tbl[3] = '{8'd255, 12'h255};
        tbl[4] = '{8'd1,   12'h001};
        tbl[5] = '{8'd9,   12'h009};
        tbl[6] = '{8'd10,  12'h010};
        tbl[7] = '{8'd199, 12'h199};
        tbl[8] = '{8'd64,  12'h064};
        tbl[9] = '{8'd250, 12'h250};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd_out", 32'(bcd_out), 32'd0);

        // Latency and busy for 255
        out_ready = 1'b1;
        send(8'd255, 12'h255, 1'b1, acc);
        lat = 0;
        bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (!busy || in_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("lat_edges", 32'(lat), 32'd8);
        chk("busy_during", 32'(bad), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
`ifdef BIN_TO_BCD_OVF_EN
        chk("ovf_255_d3", 32'(ovf1), 32'd0);
`endif
        drain();

        // Back-to-back table with out_ready tied high
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].bin, tbl[i].bcd, 1'b1, acc);
            acc_cyc[i] = acc;
        end
        for (int i = 1; i < 10; i++) chk("accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd10);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle", 32'(bcd_out), 32'h250);

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        send(8'd128, 12'h128, 1'b1, acc);
        for (int k = 0; k < 30; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        bin_in   = 8'd7;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bcd_out !== 12'h128 || in_ready || !out_valid) bad = 1'b1;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        send(8'd7, 12'h007, 1'b1, acc);
        drain();

        // Reset four cycles into SHIFT of 200
        send(8'd200, 12'h000, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad = 1'b1;
        end
        chk("mid_rst_no_output", 32'(bad), 32'd0);
        send(8'd42, 12'h042, 1'b1, acc);
        drain();

        // rst and in_valid on the same edge
        rst      = 1'b1;
        in_valid = 1'b1;
        bin_in   = 8'd55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || busy || !in_ready) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rst_vs_valid", 32'(bad), 32'd0);

        // DIGITS=2 truncation (and ovf when enabled)
        run2(8'd100, 8'h00);
`ifdef BIN_TO_BCD_OVF_EN
        chk("d2_ovf_100", 32'(ovf2), 32'd1);
`endif
        release2();
        run2(8'd99, 8'h99);
`ifdef BIN_TO_BCD_OVF_EN
        chk("d2_ovf_99", 32'(ovf2), 32'd0);
`endif
        release2();
        run2(8'd255, 8'h55);
`ifdef BIN_TO_BCD_OVF_EN
        chk("d2_ovf_255", 32'(ovf2), 32'd1);
`endif
        release2();
        chk("d2_idle", 32'(ir2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
